// File: rtl/ysyx_22040759_mdu_if.sv
// Bundle between the EXE stage and the iterative multiply/divide unit.
// The EXE side (master) presents one M-extension instruction and its operands.
// The unit (slave) reports progress and returns the registered rd value.
interface ysyx_22040759_mdu_if;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        mdu_word;
    logic [63:0] mdu_src1;
    logic [63:0] mdu_src2;
    logic        mdu_flush;
    logic        ms_allowin;
    logic        mdu_busy;
    logic        mdu_done;
    logic [63:0] mdu_result;

    modport master (
        output mdu_start, mdu_op, mdu_word, mdu_src1, mdu_src2, mdu_flush, ms_allowin,
        input  mdu_busy, mdu_done, mdu_result
    );

    modport slave (
        input  mdu_start, mdu_op, mdu_word, mdu_src1, mdu_src2, mdu_flush, ms_allowin,
        output mdu_busy, mdu_done, mdu_result
    );
endinterface

// File: rtl/ysyx_22040759_mdu.sv
// Iterative RV64M multiply/divide unit with its IDLE/CALC/DONE sequencer.
// Multiply is a 64-step shift-add on operand magnitudes; divide is a 64-step
// restoring division. Sign fix-up and word-form extension happen on the edge
// that loads the result. Divide-by-zero and signed overflow bypass CALC.
module ysyx_22040759_mdu (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22040759_mdu_if.slave        mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_r;
    state_e      state_nxt_s;
    logic [6:0]  cnt_r;
    logic [2:0]  op_r;
    logic        word_r;
    logic        neg_a_r;
    logic        neg_b_r;
    // hi_r: multiply accumulator high half / divide partial remainder
    // lo_r: multiplier being shifted out / dividend shifting in, quotient shifting in
    // b_r : multiplicand / divisor magnitude
    logic [63:0] hi_r;
    logic [63:0] lo_r;
    logic [63:0] b_r;
    logic        busy_r;
    logic        done_r;
    logic [63:0] result_r;

    // operand preparation (issue-side, combinational)
    logic        is_div_s;
    logic        word_s;
    logic        zext_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [63:0] a_mag_s;
    logic [63:0] b_mag_s;
    logic [63:0] dividend_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [63:0] special_res_s;

    // iteration step and final result
    logic [64:0]  mul_sum_s;
    logic [64:0]  div_shift_s;
    logic [63:0]  div_diff_s;
    logic         div_ge_s;
    logic [63:0]  hi_nxt_s;
    logic [63:0]  lo_nxt_s;
    logic [127:0] prod_s;
    logic [63:0]  quo_s;
    logic [63:0]  rem_s;
    logic [63:0]  final_res_s;

    // control strobes
    logic         issue_calc_s;
    logic         load_special_s;
    logic         load_final_s;

    // Sign-extend the low word of a 64-bit value.
    function automatic logic [63:0] sext32(input logic [63:0] v);
        sext32 = {{32{v[31]}}, v[31:0]};
    endfunction

    // Two's complement negate when requested.
    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        if (neg) begin
            cond_neg64 = 64'd0 - v;
        end else begin
            cond_neg64 = v;
        end
    endfunction

    // Decode the issuing op: extension, signedness, magnitudes and special cases.
    always_comb begin
        is_div_s = mdu.mdu_op[2];
        word_s   = mdu.mdu_word & (mdu.mdu_op[2] | (mdu.mdu_op[1:0] == 2'b00));
        zext_s   = mdu.mdu_op[2] & mdu.mdu_op[0];
        sign_a_s = (mdu.mdu_op == 3'b001) | (mdu.mdu_op == 3'b010) |
                   (mdu.mdu_op == 3'b100) | (mdu.mdu_op == 3'b110);
        sign_b_s = (mdu.mdu_op == 3'b001) | (mdu.mdu_op == 3'b100) |
                   (mdu.mdu_op == 3'b110);

        if (word_s && zext_s) begin
            a_ext_s = {32'd0, mdu.mdu_src1[31:0]};
            b_ext_s = {32'd0, mdu.mdu_src2[31:0]};
        end else if (word_s) begin
            a_ext_s = sext32(mdu.mdu_src1);
            b_ext_s = sext32(mdu.mdu_src2);
        end else begin
            a_ext_s = mdu.mdu_src1;
            b_ext_s = mdu.mdu_src2;
        end

        neg_a_s = sign_a_s & a_ext_s[63];
        neg_b_s = sign_b_s & b_ext_s[63];
        a_mag_s = cond_neg64(a_ext_s, neg_a_s);
        b_mag_s = cond_neg64(b_ext_s, neg_b_s);

        // Word remainders by zero return the sign-extended low word of src1.
        if (word_s) begin
            dividend_s = sext32(mdu.mdu_src1);
        end else begin
            dividend_s = mdu.mdu_src1;
        end

        div_zero_s = is_div_s & (b_ext_s == 64'd0);
        if (word_s) begin
            div_ovf_s = is_div_s & sign_a_s & (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF) &
                        (a_ext_s == 64'hFFFF_FFFF_8000_0000);
        end else begin
            div_ovf_s = is_div_s & sign_a_s & (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF) &
                        (a_ext_s == 64'h8000_0000_0000_0000);
        end
        special_s = div_zero_s | div_ovf_s;

        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero_s) begin
            if (mdu.mdu_op[1]) begin
                special_res_s = dividend_s;
            end else begin
                special_res_s = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else if (div_ovf_s) begin
            if (mdu.mdu_op[1]) begin
                special_res_s = 64'd0;
            end else begin
                special_res_s = dividend_s;
            end
        end else begin
            special_res_s = 64'd0;
        end
    end

    // One iteration of shift-add or restoring divide, plus sign fix-up of the outcome.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : 65'd0);
        div_shift_s = {hi_r, lo_r[63]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        // The difference is below the divisor whenever it is kept, so 64 bits suffice.
        div_diff_s  = div_shift_s[63:0] - b_r;

        if (op_r[2]) begin
            if (div_ge_s) begin
                hi_nxt_s = div_diff_s;
                lo_nxt_s = {lo_r[62:0], 1'b1};
            end else begin
                hi_nxt_s = div_shift_s[63:0];
                lo_nxt_s = {lo_r[62:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[64:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[63:1]};
        end

        if (neg_a_r ^ neg_b_r) begin
            prod_s = 128'd0 - {hi_nxt_s, lo_nxt_s};
        end else begin
            prod_s = {hi_nxt_s, lo_nxt_s};
        end
        quo_s = cond_neg64(lo_nxt_s, neg_a_r ^ neg_b_r);
        rem_s = cond_neg64(hi_nxt_s, neg_a_r);

        case (op_r)
            3'b000: begin
                if (word_r) begin
                    final_res_s = sext32(prod_s[63:0]);
                end else begin
                    final_res_s = prod_s[63:0];
                end
            end
            3'b001, 3'b010, 3'b011: final_res_s = prod_s[127:64];
            3'b100, 3'b101: begin
                if (word_r) begin
                    final_res_s = sext32(quo_s);
                end else begin
                    final_res_s = quo_s;
                end
            end
            3'b110, 3'b111: begin
                if (word_r) begin
                    final_res_s = sext32(rem_s);
                end else begin
                    final_res_s = rem_s;
                end
            end
            default: final_res_s = 64'd0;
        endcase
    end

    // Sequencer next state; flush overrides start and acknowledge.
    always_comb begin
        state_nxt_s    = state_r;
        issue_calc_s   = 1'b0;
        load_special_s = 1'b0;
        load_final_s   = 1'b0;
        if (mdu.mdu_flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mdu.mdu_start && special_s) begin
                        state_nxt_s    = ST_DONE;
                        load_special_s = 1'b1;
                    end else if (mdu.mdu_start) begin
                        state_nxt_s  = ST_CALC;
                        issue_calc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == 7'd63) begin
                        state_nxt_s  = ST_DONE;
                        load_final_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (mdu.ms_allowin) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch at issue and per-cycle iteration of the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 7'd0;
            op_r    <= 3'd0;
            word_r  <= 1'b0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            hi_r    <= 64'd0;
            lo_r    <= 64'd0;
            b_r     <= 64'd0;
        end else if (mdu.mdu_flush) begin
            cnt_r <= 7'd0;
        end else if (issue_calc_s) begin
            cnt_r   <= 7'd0;
            op_r    <= mdu.mdu_op;
            word_r  <= word_s;
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
            hi_r    <= 64'd0;
            lo_r    <= a_mag_s;
            b_r     <= b_mag_s;
        end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r + 7'd1;
            hi_r  <= hi_nxt_s;
            lo_r  <= lo_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered status and result; the result holds only while DONE persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 64'd0;
        end else begin
            busy_r <= (state_nxt_s == ST_CALC);
            done_r <= (state_nxt_s == ST_DONE);
            if (load_special_s) begin
                result_r <= special_res_s;
            end else if (load_final_s) begin
                result_r <= final_res_s;
            end else if (state_nxt_s != ST_DONE) begin
                result_r <= 64'd0;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign mdu.mdu_busy   = busy_r;
    assign mdu.mdu_done   = done_r;
    assign mdu.mdu_result = result_r;

endmodule

// File: tb/tb_ysyx_22040759_mdu.sv
// Directed plus randomized bench for the iterative multiply/divide unit.
// Expected values come from plain wide arithmetic on the RV64M rules.
module tb_ysyx_22040759_mdu;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    ysyx_22040759_mdu_if mdu_bus ();

    ysyx_22040759_mdu u_dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] sx32(input logic [31:0] v);
        sx32 = {{32{v[31]}}, v};
    endfunction

    // Reference: RV64M result computed with wide arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       pa, pb, p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0]        ua, ub, t;
        logic [63:0]        r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        r = 64'd0;
        case (op)
            3'd0: begin
                if (word) begin t = ua * ub; r = sx32(t); end
                else r = a * b;
            end
            3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
            3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
            3'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
            3'd4: begin
                if (word) begin
                    if (ub == 32'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = sx32(ua);
                    else begin t = wa / wb; r = sx32(t); end
                end else begin
                    if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                    else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = a;
                    else r = sa / sb;
                end
            end
            3'd5: begin
                if (word) begin
                    if (ub == 32'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                    else begin t = ua / ub; r = sx32(t); end
                end else begin
                    if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                    else r = a / b;
                end
            end
            3'd6: begin
                if (word) begin
                    if (ub == 32'd0) r = sx32(ua);
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = 64'd0;
                    else begin t = wa % wb; r = sx32(t); end
                end else begin
                    if (b == 64'd0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = 64'd0;
                    else r = sa % sb;
                end
            end
            default: begin
                if (word) begin
                    if (ub == 32'd0) r = sx32(ua);
                    else begin t = ua % ub; r = sx32(t); end
                end else begin
                    if (b == 64'd0) r = a;
                    else r = a % b;
                end
            end
        endcase
        ref_model = r;
    endfunction

    // Reference: whether the op finishes in one cycle (divide by zero or signed overflow).
    function automatic bit ref_special(input logic [2:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        bit res;
        res = 1'b0;
        if (op[2]) begin
            if (word) begin
                res = (b[31:0] == 32'd0) ||
                      (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
            end else begin
                res = (b == 64'd0) ||
                      (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        ref_special = res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present an instruction at the current negedge and let the start edge pass.
    task automatic issue(input logic [2:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic allow);
        mdu_bus.mdu_start  = 1'b1;
        mdu_bus.mdu_op     = op;
        mdu_bus.mdu_word   = word;
        mdu_bus.mdu_src1   = a;
        mdu_bus.mdu_src2   = b;
        mdu_bus.ms_allowin = allow;
        @(posedge clk);
    endtask

    // Full instruction: latency, busy behaviour, result, optional MEM stall, release.
    task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input int stall);
        logic [63:0] exp;
        bit          spec;
        bit          saw_busy;
        int          k;
        exp  = ref_model(op, word, a, b);
        spec = ref_special(op, word, a, b);
        issue(op, word, a, b, (stall == 0));
        k = 0;
        saw_busy = 1'b0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (mdu_bus.mdu_busy) saw_busy = 1'b1;
            if (mdu_bus.mdu_done) break;
        end
        check({tag, ".done"}, 64'(mdu_bus.mdu_done), 64'd1);
        check({tag, ".lat"}, 64'(k), spec ? 64'd1 : 64'd65);
        check({tag, ".busy"}, 64'(saw_busy), spec ? 64'd0 : 64'd1);
        check({tag, ".res"}, mdu_bus.mdu_result, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_done"}, 64'(mdu_bus.mdu_done), 64'd1);
            check({tag, ".hold_res"}, mdu_bus.mdu_result, exp);
        end
        mdu_bus.ms_allowin = 1'b1;
        @(negedge clk);
        check({tag, ".ack_done"}, 64'(mdu_bus.mdu_done), 64'd0);
        check({tag, ".ack_res"}, mdu_bus.mdu_result, 64'd0);
        mdu_bus.mdu_start = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic        rword;
        logic [63:0] ra, rb;
        n_total = 0;
        n_pass  = 0;
        clk = 1'b0;
        rst = 1'b1;
        mdu_bus.mdu_start  = 1'b0;
        mdu_bus.mdu_op     = 3'd0;
        mdu_bus.mdu_word   = 1'b0;
        mdu_bus.mdu_src1   = 64'd0;
        mdu_bus.mdu_src2   = 64'd0;
        mdu_bus.mdu_flush  = 1'b0;
        mdu_bus.ms_allowin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.busy", 64'(mdu_bus.mdu_busy), 64'd0);
        check("reset.done", 64'(mdu_bus.mdu_done), 64'd0);
        check("reset.res", mdu_bus.mdu_result, 64'd0);

        // Directed cases from the RV64M rules.
        run_op("mul_neg3x7", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0);
        check("mul_neg3x7.ref", ref_model(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7),
              64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu_max", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
        run_op("mulh", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0);
        run_op("mulw", 3'd0, 1'b1, 64'h0000_0001_0001_0000, 64'h0000_0000_0001_0001, 0);
        run_op("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run_op("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run_op("divuw", 3'd5, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 0);
        run_op("remuw", 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0);
        run_op("divu_zero", 3'd5, 1'b0, 64'd1234, 64'd0, 0);
        run_op("rem_zero", 3'd6, 1'b0, 64'd5, 64'd0, 0);
        run_op("remuw_zero", 3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 0);
        run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remw_ovf", 3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // MEM stall with start held: result must hold and nothing restarts.
        run_op("stall_mul", 3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10);
        run_op("stall_spec", 3'd4, 1'b0, 64'd99, 64'd0, 4);
        check("stall.busy_after", 64'(mdu_bus.mdu_busy), 64'd0);

        // Flush at counter 30.
        issue(3'd4, 1'b0, 64'd1000, 64'd7, 1'b1);
        repeat (31) @(negedge clk);
        check("flush30.busy_before", 64'(mdu_bus.mdu_busy), 64'd1);
        mdu_bus.mdu_flush = 1'b1;
        mdu_bus.mdu_start = 1'b0;
        @(negedge clk);
        mdu_bus.mdu_flush = 1'b0;
        check("flush30.busy", 64'(mdu_bus.mdu_busy), 64'd0);
        check("flush30.done", 64'(mdu_bus.mdu_done), 64'd0);
        repeat (40) @(negedge clk);
        check("flush30.done_later", 64'(mdu_bus.mdu_done), 64'd0);

        // Flush on the cycle that would enter DONE.
        issue(3'd0, 1'b0, 64'd3, 64'd5, 1'b1);
        repeat (64) @(negedge clk);
        check("flush63.done_before", 64'(mdu_bus.mdu_done), 64'd0);
        mdu_bus.mdu_flush = 1'b1;
        mdu_bus.mdu_start = 1'b0;
        @(negedge clk);
        mdu_bus.mdu_flush = 1'b0;
        check("flush63.done", 64'(mdu_bus.mdu_done), 64'd0);
        check("flush63.busy", 64'(mdu_bus.mdu_busy), 64'd0);
        check("flush63.res", mdu_bus.mdu_result, 64'd0);

        // Asynchronous reset mid-CALC.
        issue(3'd0, 1'b0, 64'd11, 64'd13, 1'b1);
        repeat (20) @(negedge clk);
        check("arst.busy_before", 64'(mdu_bus.mdu_busy), 64'd1);
        #2;
        rst = 1'b1;
        mdu_bus.mdu_start = 1'b0;
        #1;
        check("arst.busy", 64'(mdu_bus.mdu_busy), 64'd0);
        check("arst.done", 64'(mdu_bus.mdu_done), 64'd0);
        check("arst.res", mdu_bus.mdu_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_1000, 0);

        // Randomized operations with bias toward boundary operands.
        for (int n = 0; n < 24; n++) begin
            rop   = 3'($urandom_range(0, 7));
            rword = 1'($urandom_range(0, 1));
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = 64'd0;
                1: rb = 64'($urandom_range(1, 20));
                2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                3: ra = 64'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rand", rop, rword, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
